// File: rtl/dram_responder.sv
// ============================================================================
// dram_responder
// ----------------------------------------------------------------------------
// Target-side endpoint of the bus arbiter's DRAM channel. The arbiter holds a
// read (w_dram_le) or write (w_dram_we_t) request until it sees busy. The
// responder then raises busy for exactly LATENCY cycles, does the access
// against an on-chip 32-bit word RAM inside that window, and presents the
// result (read data and error flag) on the edge where busy falls.
//
// After reset the whole RAM is zero-filled, one word per cycle, before
// init_done rises and the first request can be accepted.
//
// Ports:
//   CLK           clock
//   RST_X         asynchronous active-low reset
//   w_dram_addr   byte address; bits [ADDR_WIDTH+1:2] pick the word, the
//                 bits above are ignored so the address space wraps
//   w_dram_wdata  store data, right-aligned
//   w_dram_le     read request (level, held until busy is seen)
//   w_dram_we_t   write request (level, held until busy is seen)
//   w_dram_ctrl   access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   w_dram_odata  read result, right-aligned, sign/zero extended
//   w_dram_busy   transaction or zero-fill in progress
//   w_dram_err    last transaction was illegal
//   w_init_done   zero-fill complete
// ============================================================================
module dram_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] w_dram_addr,
    input  logic [31:0] w_dram_wdata,
    input  logic        w_dram_le,
    input  logic        w_dram_we_t,
    input  logic [2:0]  w_dram_ctrl,
    output logic [31:0] w_dram_odata,
    output logic        w_dram_busy,
    output logic        w_dram_err,
    output logic        w_init_done
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] FILL_LAST = '1;
    // The counter starts one below LATENCY because the acceptance edge
    // itself already opens the first busy cycle.
    localparam logic [7:0]            CNT_START = 8'(LATENCY - 1);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ACCESS,
        MERGE,
        WRBACK,
        HOLD
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] fill_ptr_q;
    logic [7:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [1:0]            lane_q;
    logic [2:0]            ctrl_q;
    logic [31:0]           wdata_q;
    logic                  is_write_q;
    logic                  illegal_q;
    logic                  err_pend_q;
    logic [31:0]           merge_q;
    logic [31:0]           rdata_q;
    logic [31:0]           odata_q;
    logic                  busy_q;
    logic                  err_q;
    logic                  init_done_q;

    logic                  legal_d;
    logic [31:0]           load_d;
    logic [31:0]           merge_d;
    logic                  done_d;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;

    logic [31:0]           mem [0:DEPTH-1];

    // Address bits above the word index only wrap, they never select storage.
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^w_dram_addr[31:ADDR_WIDTH+2];

    // Legality of the incoming request, judged at acceptance time.
    // Bytes are always aligned; halves need addr[0]=0; words need addr[1:0]=0.
    always_comb begin
        legal_d = 1'b0;
        case (w_dram_ctrl)
            3'b000, 3'b100: legal_d = 1'b1;
            3'b001, 3'b101: legal_d = ~w_dram_addr[0];
            3'b010:         legal_d = (w_dram_addr[1:0] == 2'b00);
            default:        legal_d = 1'b0;
        endcase
    end

    // Lane select and extension of the word read from RAM.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = rdata_q[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_d   = 32'h0;
        case (ctrl_q)
            3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_d = {24'h0, byte_sel};
            3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_d = {16'h0, half_sel};
            3'b010:  load_d = rdata_q;
            default: load_d = 32'h0;
        endcase
    end

    // Sub-word store: splice the new byte/half into the old word. The size
    // is taken from ctrl[1:0], so the unsigned encodings store like B/H.
    always_comb begin
        merge_d = rdata_q;
        case (ctrl_q[1:0])
            2'b00: merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (lane_q[1]) begin
                    merge_d[31:16] = wdata_q[15:0];
                end else begin
                    merge_d[15:0] = wdata_q[15:0];
                end
            end
            default: merge_d = rdata_q;
        endcase
    end

    // RAM port control. The zero-fill owns the port during INIT; afterwards
    // ACCESS either writes a full word or issues the read for loads and for
    // the read half of a read-modify-write. Illegal transactions never touch
    // the RAM. Everything is keyed on the state register, so a reset abandons
    // a pending write-back.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = word_q;
        ram_wdata = wdata_q;
        case (state_q)
            INIT: begin
                ram_we    = 1'b1;
                ram_addr  = fill_ptr_q;
                ram_wdata = 32'h0;
            end
            ACCESS: begin
                if (!illegal_q) begin
                    if (is_write_q && (ctrl_q == 3'b010)) begin
                        ram_we = 1'b1;
                    end else begin
                        ram_re = 1'b1;
                    end
                end
            end
            WRBACK: begin
                ram_we    = 1'b1;
                ram_wdata = merge_q;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // Word RAM with a one-cycle synchronous read. rdata_q only changes when
    // a read is issued, so it stays valid for the rest of the busy window.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (ram_re) begin
            rdata_q <= mem[ram_addr];
        end
    end

    // The window closes once the op has finished and the padding counter
    // has run out.
    assign done_d = ((state_q == WRBACK) || (state_q == HOLD)) && (cnt_q == 8'd0);

    // Main controller. The case handles sequencing; the trailing done_d block
    // closes the window and publishes the result on the edge busy falls.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q     <= INIT;
            fill_ptr_q  <= '0;
            cnt_q       <= 8'd0;
            word_q      <= '0;
            lane_q      <= 2'b00;
            ctrl_q      <= 3'b000;
            wdata_q     <= 32'h0;
            is_write_q  <= 1'b0;
            illegal_q   <= 1'b0;
            err_pend_q  <= 1'b0;
            merge_q     <= 32'h0;
            odata_q     <= 32'h0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (fill_ptr_q == FILL_LAST) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        fill_ptr_q <= fill_ptr_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_dram_le || w_dram_we_t) begin
                        state_q    <= ACCESS;
                        word_q     <= w_dram_addr[ADDR_WIDTH+1:2];
                        lane_q     <= w_dram_addr[1:0];
                        ctrl_q     <= w_dram_ctrl;
                        wdata_q    <= w_dram_wdata;
                        // A simultaneous read and write is served as a read
                        // but still flagged as an error.
                        is_write_q <= w_dram_we_t & ~w_dram_le;
                        illegal_q  <= ~legal_d;
                        err_pend_q <= ~legal_d | (w_dram_le & w_dram_we_t);
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= CNT_START;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (is_write_q && !illegal_q && (ctrl_q != 3'b010)) begin
                        state_q <= MERGE;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                MERGE: begin
                    cnt_q   <= cnt_q - 8'd1;
                    merge_q <= merge_d;
                    state_q <= WRBACK;
                end
                WRBACK: begin
                    cnt_q   <= cnt_q - 8'd1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    cnt_q <= cnt_q - 8'd1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (done_d) begin
                state_q <= IDLE;
                cnt_q   <= 8'd0;
                busy_q  <= 1'b0;
                err_q   <= err_pend_q;
                // Writes leave odata alone; an illegal read returns zero.
                if (!is_write_q) begin
                    odata_q <= illegal_q ? 32'h0 : load_d;
                end
            end
        end
    end

    assign w_dram_odata = odata_q;
    assign w_dram_busy  = busy_q;
    assign w_dram_err   = err_q;
    assign w_init_done  = init_done_q;

endmodule
